alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with single-cycle ops and a WIDTH-cycle shift-add multiplier.
// The multiplier is built only when ALU_SEQ_MUL_EN is defined; otherwise op 111 reports err.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic accept, go_busy, mul_last;
  logic [WIDTH:0] sum, dif;
  logic add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res, mul_res;
  logic alu_c, alu_v, alu_e, mul_c;

  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign dif       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (op)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_ovf;
      end
      3'b001: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_v   = sub_ovf;
      end
      3'b010:  alu_res = ~a;
      3'b011:  alu_res = a & b;
      3'b100:  alu_res = a | b;
      3'b101:  alu_res = a ^ b;
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ sub_ovf};
      default: alu_e = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     hi_sum;

  // prod holds the partial product in its upper half and the unconsumed multiplier bits below
  assign go_busy  = op == 3'b111;
  assign mul_last = cnt == CW'(WIDTH);
  assign hi_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign mul_res  = prod[WIDTH-1:0];
  assign mul_c    = |prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (accept && go_busy) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == BUSY && !mul_last) begin
      prod <= {hi_sum, prod[WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
    end
`else
  assign go_busy  = 1'b0;
  assign mul_last = 1'b0;
  assign mul_res  = '0;
  assign mul_c    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = go_busy ? BUSY : DONE;
      BUSY:    if (mul_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = accept ? (go_busy ? BUSY : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (accept && !go_busy) begin
      result <= alu_res;
      flags  <= {alu_e, alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c};
    end else if (state == BUSY && mul_last) begin
      result <= mul_res;
      flags  <= {1'b0, mul_res[WIDTH-1], mul_res == '0, 1'b0, mul_c};
    end
endmodule
